// File: rtl/center_of_mass_nch.sv
// Multi-channel centre-of-mass engine: per-channel x/y sums and pixel counts, serially divided on tabulate.
// Optional per-channel bounding box outputs are enabled by defining COM_BBOX_EN.
module center_of_mass_nch #(
    parameter int HWIDTH    = 11,
    parameter int VWIDTH    = 10,
    parameter int CHANNELS  = 2,
    parameter int MIN_COUNT = 16,
    localparam int CW       = HWIDTH + VWIDTH,
    localparam int SXW      = HWIDTH + CW,
    localparam int SYW      = VWIDTH + CW,
    localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int D        = SXW
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [HWIDTH-1:0] x_in,
    input  logic [VWIDTH-1:0] y_in,
    input  logic [CHW-1:0]    ch_in,
    input  logic              valid_in,
    input  logic              tabulate_in,
    output logic [HWIDTH-1:0] x_out,
    output logic [VWIDTH-1:0] y_out,
    output logic [CHW-1:0]    ch_out,
    output logic [CW-1:0]     count_out,
    output logic              found_out,
    output logic              valid_out,
    output logic              busy_out
`ifdef COM_BBOX_EN
    ,
    output logic [HWIDTH-1:0] xmin_out,
    output logic [HWIDTH-1:0] xmax_out,
    output logic [VWIDTH-1:0] ymin_out,
    output logic [VWIDTH-1:0] ymax_out
`endif
);

    localparam int CTW = (D > 1) ? $clog2(D) : 1;
    localparam logic [CHW-1:0] LAST_CH = CHW'(CHANNELS - 1);
    localparam logic [CW-1:0]  MIN_CNT = CW'(MIN_COUNT);
    localparam logic [CTW-1:0] LAST_CYC = CTW'(D - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DIV  = 2'd2,
        S_EMIT = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic [CHW-1:0] chan_q, chan_d;
    logic [CTW-1:0] cyc_q, cyc_d;

    logic [SXW-1:0] sum_x_q [CHANNELS];
    logic [SXW-1:0] sum_x_d [CHANNELS];
    logic [SYW-1:0] sum_y_q [CHANNELS];
    logic [SYW-1:0] sum_y_d [CHANNELS];
    logic [CW-1:0]  cnt_q   [CHANNELS];
    logic [CW-1:0]  cnt_d   [CHANNELS];
    logic [CHANNELS-1:0] hit_s;
    logic clear_s;

    logic [SXW-1:0] xquo_q, xquo_d, yquo_q, yquo_d;
    logic [CW-1:0]  xrem_q, xrem_d, yrem_q, yrem_d;
    logic [CW-1:0]  dvs_q, dvs_d;
    logic           found_s;

    logic [HWIDTH-1:0] x_out_q, x_out_d;
    logic [VWIDTH-1:0] y_out_q, y_out_d;
    logic [CHW-1:0]    ch_out_q, ch_out_d;
    logic [CW-1:0]     count_out_q, count_out_d;
    logic              found_out_q, found_out_d;
    logic              valid_out_q, valid_out_d;
    logic              busy_out_q, busy_out_d;

`ifdef COM_BBOX_EN
    logic [HWIDTH-1:0] xmin_q [CHANNELS];
    logic [HWIDTH-1:0] xmin_d [CHANNELS];
    logic [HWIDTH-1:0] xmax_q [CHANNELS];
    logic [HWIDTH-1:0] xmax_d [CHANNELS];
    logic [VWIDTH-1:0] ymin_q [CHANNELS];
    logic [VWIDTH-1:0] ymin_d [CHANNELS];
    logic [VWIDTH-1:0] ymax_q [CHANNELS];
    logic [VWIDTH-1:0] ymax_d [CHANNELS];
    logic [HWIDTH-1:0] xmin_out_q, xmin_out_d, xmax_out_q, xmax_out_d;
    logic [VWIDTH-1:0] ymin_out_q, ymin_out_d, ymax_out_q, ymax_out_d;
`endif

    // One restoring-division step: shift in the dividend MSB, subtract when it fits.
    // A zero divisor never subtracts, so its quotient stays 0.
    function automatic logic [CW+SXW-1:0] div_step(
        input logic [CW-1:0]  rem,
        input logic [SXW-1:0] quo,
        input logic [CW-1:0]  dvs
    );
        logic [CW:0]   sh;
        logic [CW-1:0] rem_n;
        logic          qbit;
        sh = {rem, quo[SXW-1]};
        if ((dvs != {CW{1'b0}}) && (sh >= {1'b0, dvs})) begin
            rem_n = CW'(sh - {1'b0, dvs});
            qbit  = 1'b1;
        end else begin
            rem_n = sh[CW-1:0];
            qbit  = 1'b0;
        end
        return {rem_n, quo[SXW-2:0], qbit};
    endfunction

    assign found_s = (dvs_q != {CW{1'b0}}) && (dvs_q >= MIN_CNT);
    assign clear_s = (state_q == S_EMIT) && (chan_q == LAST_CH);

    // Per-channel accumulation in IDLE; saturated channels and unknown channels drop the pixel.
    always_comb begin
        hit_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            sum_x_d[i] = sum_x_q[i];
            sum_y_d[i] = sum_y_q[i];
            cnt_d[i]   = cnt_q[i];
            hit_s[i]   = (state_q == S_IDLE) && valid_in && (ch_in == CHW'(i))
                         && (cnt_q[i] != {CW{1'b1}});
            if (clear_s) begin
                sum_x_d[i] = {SXW{1'b0}};
                sum_y_d[i] = {SYW{1'b0}};
                cnt_d[i]   = {CW{1'b0}};
            end else if (hit_s[i]) begin
                sum_x_d[i] = sum_x_q[i] + SXW'(x_in);
                sum_y_d[i] = sum_y_q[i] + SYW'(y_in);
                cnt_d[i]   = cnt_q[i] + CW'(1);
            end else begin
                cnt_d[i]   = cnt_q[i];
            end
        end
    end

`ifdef COM_BBOX_EN
    // Bounding-box trackers follow the same accept/clear rules as the sums.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            xmin_d[i] = xmin_q[i];
            xmax_d[i] = xmax_q[i];
            ymin_d[i] = ymin_q[i];
            ymax_d[i] = ymax_q[i];
            if (clear_s) begin
                xmin_d[i] = {HWIDTH{1'b1}};
                xmax_d[i] = {HWIDTH{1'b0}};
                ymin_d[i] = {VWIDTH{1'b1}};
                ymax_d[i] = {VWIDTH{1'b0}};
            end else if (hit_s[i]) begin
                xmin_d[i] = (x_in < xmin_q[i]) ? x_in : xmin_q[i];
                xmax_d[i] = (x_in > xmax_q[i]) ? x_in : xmax_q[i];
                ymin_d[i] = (y_in < ymin_q[i]) ? y_in : ymin_q[i];
                ymax_d[i] = (y_in > ymax_q[i]) ? y_in : ymax_q[i];
            end else begin
                xmin_d[i] = xmin_q[i];
            end
        end
    end
`endif

    // Tabulation FSM, dividers and registered result outputs.
    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        cyc_d       = cyc_q;
        xquo_d      = xquo_q;
        yquo_d      = yquo_q;
        xrem_d      = xrem_q;
        yrem_d      = yrem_q;
        dvs_d       = dvs_q;
        x_out_d     = x_out_q;
        y_out_d     = y_out_q;
        ch_out_d    = ch_out_q;
        count_out_d = count_out_q;
        found_out_d = found_out_q;
        valid_out_d = 1'b0;
`ifdef COM_BBOX_EN
        xmin_out_d  = xmin_out_q;
        xmax_out_d  = xmax_out_q;
        ymin_out_d  = ymin_out_q;
        ymax_out_d  = ymax_out_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (tabulate_in) begin
                    state_d = S_LOAD;
                    chan_d  = {CHW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                xquo_d  = sum_x_q[chan_q];
                yquo_d  = SXW'(sum_y_q[chan_q]);
                xrem_d  = {CW{1'b0}};
                yrem_d  = {CW{1'b0}};
                dvs_d   = cnt_q[chan_q];
                cyc_d   = {CTW{1'b0}};
                state_d = S_DIV;
            end
            S_DIV: begin
                {xrem_d, xquo_d} = div_step(xrem_q, xquo_q, dvs_q);
                {yrem_d, yquo_d} = div_step(yrem_q, yquo_q, dvs_q);
                cyc_d = cyc_q + CTW'(1);
                if (cyc_q == LAST_CYC) begin
                    state_d = S_EMIT;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_EMIT: begin
                valid_out_d = 1'b1;
                ch_out_d    = chan_q;
                count_out_d = dvs_q;
                found_out_d = found_s;
                x_out_d     = found_s ? xquo_q[HWIDTH-1:0] : {HWIDTH{1'b0}};
                y_out_d     = found_s ? yquo_q[VWIDTH-1:0] : {VWIDTH{1'b0}};
`ifdef COM_BBOX_EN
                xmin_out_d  = found_s ? xmin_q[chan_q] : {HWIDTH{1'b0}};
                xmax_out_d  = found_s ? xmax_q[chan_q] : {HWIDTH{1'b0}};
                ymin_out_d  = found_s ? ymin_q[chan_q] : {VWIDTH{1'b0}};
                ymax_out_d  = found_s ? ymax_q[chan_q] : {VWIDTH{1'b0}};
`endif
                if (chan_q == LAST_CH) begin
                    state_d = S_IDLE;
                end else begin
                    chan_d  = chan_q + CHW'(1);
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_out_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            chan_q      <= {CHW{1'b0}};
            cyc_q       <= {CTW{1'b0}};
            xquo_q      <= {SXW{1'b0}};
            yquo_q      <= {SXW{1'b0}};
            xrem_q      <= {CW{1'b0}};
            yrem_q      <= {CW{1'b0}};
            dvs_q       <= {CW{1'b0}};
            x_out_q     <= {HWIDTH{1'b0}};
            y_out_q     <= {VWIDTH{1'b0}};
            ch_out_q    <= {CHW{1'b0}};
            count_out_q <= {CW{1'b0}};
            found_out_q <= 1'b0;
            valid_out_q <= 1'b0;
            busy_out_q  <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                sum_x_q[i] <= {SXW{1'b0}};
                sum_y_q[i] <= {SYW{1'b0}};
                cnt_q[i]   <= {CW{1'b0}};
            end
`ifdef COM_BBOX_EN
            xmin_out_q <= {HWIDTH{1'b0}};
            xmax_out_q <= {HWIDTH{1'b0}};
            ymin_out_q <= {VWIDTH{1'b0}};
            ymax_out_q <= {VWIDTH{1'b0}};
            for (int i = 0; i < CHANNELS; i++) begin
                xmin_q[i] <= {HWIDTH{1'b1}};
                xmax_q[i] <= {HWIDTH{1'b0}};
                ymin_q[i] <= {VWIDTH{1'b1}};
                ymax_q[i] <= {VWIDTH{1'b0}};
            end
`endif
        end else begin
            state_q     <= state_d;
            chan_q      <= chan_d;
            cyc_q       <= cyc_d;
            xquo_q      <= xquo_d;
            yquo_q      <= yquo_d;
            xrem_q      <= xrem_d;
            yrem_q      <= yrem_d;
            dvs_q       <= dvs_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            ch_out_q    <= ch_out_d;
            count_out_q <= count_out_d;
            found_out_q <= found_out_d;
            valid_out_q <= valid_out_d;
            busy_out_q  <= busy_out_d;
            sum_x_q     <= sum_x_d;
            sum_y_q     <= sum_y_d;
            cnt_q       <= cnt_d;
`ifdef COM_BBOX_EN
            xmin_out_q  <= xmin_out_d;
            xmax_out_q  <= xmax_out_d;
            ymin_out_q  <= ymin_out_d;
            ymax_out_q  <= ymax_out_d;
            xmin_q      <= xmin_d;
            xmax_q      <= xmax_d;
            ymin_q      <= ymin_d;
            ymax_q      <= ymax_d;
`endif
        end
    end

    assign x_out     = x_out_q;
    assign y_out     = y_out_q;
    assign ch_out    = ch_out_q;
    assign count_out = count_out_q;
    assign found_out = found_out_q;
    assign valid_out = valid_out_q;
    assign busy_out  = busy_out_q;
`ifdef COM_BBOX_EN
    assign xmin_out  = xmin_out_q;
    assign xmax_out  = xmax_out_q;
    assign ymin_out  = ymin_out_q;
    assign ymax_out  = ymax_out_q;
`endif

endmodule
